spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl_if.sv | 34 +++
 rtl/spi_master_ctrl.sv | 177 +++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl_if
//   Bundles the request handshake and the SPI pins of spi_master_ctrl.
//
//   Request side : req, rw, addr[6:0], wdata[7:0]   (host -> controller)
//   Status side  : busy, done, rdata[7:0]           (controller -> host)
//   SPI pins     : cs, sclk, mosi (out), miso (in)
//
//   modport master : the controller itself (it is the SPI master)
//   modport slave  : everything around it (host logic and the SPI device)
// ---------------------------------------------------------------------------
interface spi_master_ctrl_if;
  logic       req;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       cs;
  logic       sclk;
  logic       mosi;
  logic       miso;

  modport master (
    input  req, rw, addr, wdata, miso,
    output busy, done, rdata, cs, sclk, mosi
  );

  modport slave (
    output req, rw, addr, wdata, miso,
    input  busy, done, rdata, cs, sclk, mosi
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// spi_master_ctrl
//   Mode-0 SPI master issuing one command byte {addr, rw} followed, after a
//   turnaround with sclk parked low, by one data byte (wdata on writes,
//   zeros on reads while miso is captured into rdata).
//
//   Parameters
//     CLKDIV : clk cycles per sclk half-period (2..255)
//     TURN   : clk cycles between command and data byte (1..255)
//     GAP    : minimum clk cycles of cs high between transactions (1..255)
//
//   Ports
//     clk, reset : clock and synchronous active-high reset
//     bus        : spi_master_ctrl_if.master (request, status and SPI pins)
//
//   A transaction takes 34*CLKDIV+TURN cycles from acceptance to done and
//   GAP more cycles until busy drops.
// ---------------------------------------------------------------------------
module spi_master_ctrl #(
  parameter int CLKDIV = 4,
  parameter int TURN   = 8,
  parameter int GAP    = 4
) (
  input logic               clk,
  input logic               reset,
  spi_master_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_TURN,
    S_DATA,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLKDIV - 1);
  localparam logic [7:0] TURN_LAST = 8'(TURN - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);

  state_t     state;
  logic [7:0] cnt;       // divider in SETUP/CMD/DATA/HOLD, wait counter in TURN/GAP
  logic [3:0] bit_cnt;   // bit index within the current byte
  logic       rw_q;
  logic [7:0] wdata_q;
  logic [7:0] tx_sr;     // bits still to be presented on mosi, MSB next
  logic [7:0] rx_sr;

  logic       cs_r;
  logic       sclk_r;
  logic       mosi_r;
  logic       busy_r;
  logic       done_r;
  logic [7:0] rdata_r;

  logic       half_end;
  assign half_end = (cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      cs_r    <= 1'b1;
      sclk_r  <= 1'b0;
      mosi_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rdata_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            rw_q    <= bus.rw;
            wdata_q <= bus.wdata;
            // Command byte is {addr, rw}: its MSB goes out now, the rest is queued.
            mosi_r  <= bus.addr[6];
            tx_sr   <= {bus.addr[5:0], bus.rw, 1'b0};
            busy_r  <= 1'b1;
            cs_r    <= 1'b0;
            cnt     <= '0;
            state   <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (half_end) begin
            cnt     <= '0;
            bit_cnt <= '0;
            sclk_r  <= 1'b1;
            state   <= S_CMD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_CMD, S_DATA: begin
          if (!half_end) begin
            cnt <= cnt + 8'd1;
          end else begin
            cnt <= '0;
            if (sclk_r) begin
              // End of the high half: capture miso, drop sclk and present the
              // next bit. The last bit of a byte stays on mosi until phase exit.
              sclk_r <= 1'b0;
              rx_sr  <= {rx_sr[6:0], bus.miso};
              if (bit_cnt != 4'd7) begin
                mosi_r <= tx_sr[7];
                tx_sr  <= {tx_sr[6:0], 1'b0};
              end
            end else if (bit_cnt == 4'd7) begin
              // Byte finished: sclk stays low into the next phase, no extra pulse.
              bit_cnt <= '0;
              mosi_r  <= 1'b0;
              state   <= (state == S_CMD) ? S_TURN : S_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              sclk_r  <= 1'b1;
            end
          end
        end

        S_TURN: begin
          if (cnt == TURN_LAST) begin
            cnt     <= '0;
            bit_cnt <= '0;
            sclk_r  <= 1'b1;
            mosi_r  <= rw_q ? 1'b0 : wdata_q[7];
            tx_sr   <= rw_q ? 8'h00 : {wdata_q[6:0], 1'b0};
            state   <= S_DATA;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_HOLD: begin
          if (half_end) begin
            cnt    <= '0;
            cs_r   <= 1'b1;
            done_r <= 1'b1;
            if (rw_q) begin
              rdata_r <= rx_sr;
            end
            state  <= S_GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt    <= '0;
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cs    = cs_r;
  assign bus.sclk  = sclk_r;
  assign bus.mosi  = mosi_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_master_ctrl
//   Directed bench for spi_master_ctrl. dut_a runs the default parameters,
//   dut_b runs CLKDIV=2, TURN=1. A cycle-by-cycle observer records sclk
//   rising edges, mosi at each rise, done/busy timing, sclk phase lengths
//   and cs gaps, and plays a slave that returns a byte during the data phase.
// ---------------------------------------------------------------------------
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_master_ctrl_if ifa ();
  spi_master_ctrl_if ifb ();

  spi_master_ctrl #(.CLKDIV(4), .TURN(8), .GAP(4)) dut_a (
    .clk  (clk),
    .reset(reset),
    .bus  (ifa.master)
  );

  spi_master_ctrl #(.CLKDIV(2), .TURN(1), .GAP(4)) dut_b (
    .clk  (clk),
    .reset(reset),
    .bus  (ifb.master)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Observer results
  int          rises;
  int          done_cnt;
  int          done_t;
  int          busy_fall_t;
  int          gaps;
  int          gap_min;
  int          gap_max;
  int          hi_min;
  int          hi_max;
  int          lo_min;
  int          lo_max;
  logic [15:0] mosi_bits;
  logic [7:0]  rdata_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input bit sel, input bit req, input bit rw,
                       input logic [6:0] addr, input logic [7:0] wd);
    if (sel) begin
      ifb.req = req; ifb.rw = rw; ifb.addr = addr; ifb.wdata = wd;
    end else begin
      ifa.req = req; ifa.rw = rw; ifa.addr = addr; ifa.wdata = wd;
    end
  endtask

  task automatic set_req(input bit sel, input bit v);
    if (sel) ifb.req = v;
    else     ifa.req = v;
  endtask

  task automatic set_miso(input bit sel, input bit v);
    if (sel) ifb.miso = v;
    else     ifa.miso = v;
  endtask

  // Returns at the negedge right after the acceptance edge.
  task automatic start(input bit sel, input bit rw, input logic [6:0] a,
                       input logic [7:0] wd, input bit hold);
    @(negedge clk);
    drive(sel, 1'b1, rw, a, wd);
    @(negedge clk);
    if (!hold) set_req(sel, 1'b0);
  endtask

  // t counts clk edges since acceptance; samples are taken on negedges.
  task automatic observe(input bit sel, input int budget, input int req_drop_t,
                         input int poke_t, input logic [7:0] slave_byte);
    logic       s_sclk, s_cs, s_busy, s_done, s_mosi;
    logic [7:0] s_rdata;
    logic       prev_sclk, prev_cs;
    logic [7:0] sb;
    int         run, cs_run, k;
    prev_sclk = 1'b0; prev_cs = 1'b0; sb = slave_byte;
    run = 0; cs_run = 0; k = 0;
    rises = 0; done_cnt = 0; done_t = -1; busy_fall_t = -1;
    gaps = 0; gap_min = 1000; gap_max = 0;
    hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
    mosi_bits = '0; rdata_done = '0;
    set_miso(sel, 1'b0);
    for (int t = 0; t <= budget; t++) begin
      s_sclk  = sel ? ifb.sclk  : ifa.sclk;
      s_cs    = sel ? ifb.cs    : ifa.cs;
      s_busy  = sel ? ifb.busy  : ifa.busy;
      s_done  = sel ? ifb.done  : ifa.done;
      s_mosi  = sel ? ifb.mosi  : ifa.mosi;
      s_rdata = sel ? ifb.rdata : ifa.rdata;

      if (s_cs) begin
        k = 0;
        sb = slave_byte;
        cs_run = prev_cs ? cs_run + 1 : 1;
      end else if (prev_cs) begin
        gaps++;
        if (cs_run < gap_min) gap_min = cs_run;
        if (cs_run > gap_max) gap_max = cs_run;
      end

      if (s_sclk != prev_sclk) begin
        if (prev_sclk) begin
          if (run < hi_min) hi_min = run;
          if (run > hi_max) hi_max = run;
        end else if (k != 0 && k != 8) begin
          if (run < lo_min) lo_min = run;
          if (run > lo_max) lo_max = run;
        end
        run = 0;
      end
      run++;

      if (s_sclk && !prev_sclk) begin
        k++;
        rises++;
        if (rises <= 16) mosi_bits = {mosi_bits[14:0], s_mosi};
        if (k >= 9) begin
          set_miso(sel, sb[7]);
          sb = {sb[6:0], 1'b0};
        end else begin
          set_miso(sel, 1'b0);
        end
      end

      if (s_done) begin
        done_cnt++;
        if (done_t < 0) begin
          done_t = t;
          rdata_done = s_rdata;
        end
      end
      if (!s_busy && busy_fall_t < 0) busy_fall_t = t;

      if (t == req_drop_t) set_req(sel, 1'b0);
      if (t == poke_t) drive(sel, 1'b1, 1'b0, 7'h6A, 8'h5A);
      if (t == poke_t + 1) set_req(sel, 1'b0);

      prev_sclk = s_sclk;
      prev_cs   = s_cs;
      @(negedge clk);
    end
  endtask

  initial begin
    int r;
    int dn;
    logic pv;

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 7'h00, 8'h00);
    set_miso(1'b0, 1'b0);
    set_miso(1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_cs",    32'(ifa.cs),    32'h1);
    check("rst_sclk",  32'(ifa.sclk),  32'h0);
    check("rst_mosi",  32'(ifa.mosi),  32'h0);
    check("rst_busy",  32'(ifa.busy),  32'h0);
    check("rst_done",  32'(ifa.done),  32'h0);
    check("rst_rdata", 32'(ifa.rdata), 32'h0);
    check("rst_b_cs",  32'(ifb.cs),    32'h1);
    reset = 1'b0;

    // Write 0x15 <- 0xA5 at defaults
    start(1'b0, 1'b0, 7'h15, 8'hA5, 1'b0);
    check("wr_busy_acc", 32'(ifa.busy), 32'h1);
    check("wr_cs_acc",   32'(ifa.cs),   32'h0);
    observe(1'b0, 160, -1, -10, 8'h00);
    check("wr_cmd",       32'(mosi_bits[15:8]), 32'h2A);
    check("wr_data",      32'(mosi_bits[7:0]),  32'hA5);
    check("wr_rises",     rises,                16);
    check("wr_done_t",    done_t,               144);
    check("wr_done_cnt",  done_cnt,             1);
    check("wr_busy_fall", busy_fall_t,          148);

    // Read 0x15, slave returns 0x3C
    start(1'b0, 1'b1, 7'h15, 8'hFF, 1'b0);
    observe(1'b0, 160, -1, -10, 8'h3C);
    check("rd_cmd",    32'(mosi_bits[15:8]), 32'h2B);
    check("rd_data",   32'(mosi_bits[7:0]),  32'h00);
    check("rd_rdata",  32'(rdata_done),      32'h3C);
    check("rd_done_t", done_t,               144);

    // A following write leaves rdata untouched
    start(1'b0, 1'b0, 7'h40, 8'h81, 1'b0);
    observe(1'b0, 160, -1, -10, 8'hC3);
    check("wr2_cmd",   32'(mosi_bits[15:8]), 32'h80);
    check("wr2_data",  32'(mosi_bits[7:0]),  32'h81);
    check("wr2_rdata", 32'(rdata_done),      32'h3C);

    // Reset while CMD bit 3 is on the wire
    start(1'b0, 1'b0, 7'h15, 8'hA5, 1'b0);
    r = 0;
    pv = 1'b0;
    for (int g = 0; g < 100 && r < 4; g++) begin
      if (ifa.sclk && !pv) r++;
      pv = ifa.sclk;
      if (r < 4) @(negedge clk);
    end
    check("abort_reached_bit3", r, 4);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cs",   32'(ifa.cs),   32'h1);
    check("abort_sclk", 32'(ifa.sclk), 32'h0);
    check("abort_busy", 32'(ifa.busy), 32'h0);
    check("abort_mosi", 32'(ifa.mosi), 32'h0);
    reset = 1'b0;
    dn = 0;
    for (int g = 0; g < 200; g++) begin
      if (ifa.done) dn++;
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);
    start(1'b0, 1'b0, 7'h15, 8'hA5, 1'b0);
    observe(1'b0, 160, -1, -10, 8'h00);
    check("post_abort_cmd",    32'(mosi_bits[15:8]), 32'h2A);
    check("post_abort_done_t", done_t,               144);

    // req pulsed during DATA with different inputs
    start(1'b0, 1'b0, 7'h15, 8'hA5, 1'b0);
    observe(1'b0, 320, -1, 100, 8'h00);
    check("poke_cmd",      32'(mosi_bits[15:8]), 32'h2A);
    check("poke_data",     32'(mosi_bits[7:0]),  32'hA5);
    check("poke_rises",    rises,                16);
    check("poke_done_cnt", done_cnt,             1);

    // req held for three back-to-back transactions
    start(1'b0, 1'b0, 7'h15, 8'hA5, 1'b1);
    observe(1'b0, 470, 300, -10, 8'h00);
    check("b2b_rises",    rises,    48);
    check("b2b_done_cnt", done_cnt, 3);
    check("b2b_gaps",     gaps,     2);
    check("b2b_gap_min",  gap_min,  5);
    check("b2b_gap_max",  gap_max,  5);

    // CLKDIV=2, TURN=1 read, slave returns 0x96
    start(1'b1, 1'b1, 7'h33, 8'h00, 1'b0);
    observe(1'b1, 90, -1, -10, 8'h96);
    check("fast_cmd",       32'(mosi_bits[15:8]), 32'h67);
    check("fast_done_t",    done_t,               69);
    check("fast_busy_fall", busy_fall_t,          73);
    check("fast_rdata",     32'(rdata_done),      32'h96);
    check("fast_rises",     rises,                16);
    check("fast_hi_min",    hi_min,               2);
    check("fast_hi_max",    hi_max,               2);
    check("fast_lo_min",    lo_min,               2);
    check("fast_lo_max",    lo_max,               2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
